router_vc_input_unit: RTL

Parametrised virtual-channel input unit for the mesh router: one instance per router input port. It buffers incoming flits in a per-VC FIFO, returns per-VC ack/ready/lock to the upstream link, and computes the dimension-ordered (XY) output port from each head flit. It arbitrates round-robin between VCs at packet granularity and presents one flit per cycle to the switch. It generalises the fixed 2-VC, 35-bit port to any VC count, width and buffer depth, and adds overflow detection and packet-locked arbitration.

---
 rtl/router_vc_input_unit_if.sv | 31 +++
 rtl/router_vc_input_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/router_vc_input_unit_if.sv
// Link/switch bundle for router_vc_input_unit: upstream flit push with per-VC
// ack/ready/lock, and the arbitrated flit presented to the switch.
interface router_vc_input_unit_if #(
  parameter int NUM_VC = 2,
  parameter int DATA_W = 35
);
  localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  logic [DATA_W-1:0] idata;
  logic              ivalid;
  logic [VC_W-1:0]   ivch;
  logic [NUM_VC-1:0] oack;
  logic [NUM_VC-1:0] ordy;
  logic [NUM_VC-1:0] olck;
  logic [DATA_W-1:0] odata;
  logic              ovalid;
  logic [VC_W-1:0]   ovch;
  logic [4:0]        oport;
  logic              igrant;
  logic              oovf;

  modport slave (
    input  idata, ivalid, ivch, igrant,
    output oack, ordy, olck, odata, ovalid, ovch, oport, oovf
  );

  modport master (
    output idata, ivalid, ivch, igrant,
    input  oack, ordy, olck, odata, ovalid, ovch, oport, oovf
  );
endinterface

// File: rtl/router_vc_input_unit.sv
// Virtual-channel input unit: per-VC flit FIFOs, XY route computation and
// packet-granular round-robin arbitration towards the switch.
module router_vc_input_unit #(
  parameter int NUM_VC = 2,
  parameter int DATA_W = 35,
  parameter int DEPTH  = 4,
  parameter int POS_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] my_xpos,
  input  logic [POS_W-1:0] my_ypos,
  router_vc_input_unit_if.slave bus
);
  localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [CW-1:0]   FULL   = CW'(DEPTH);
  localparam logic [VC_W:0]   NVC    = (VC_W+1)'(NUM_VC);
  localparam logic [1:0]      T_HEAD = 2'b01;
  localparam logic [1:0]      T_TAIL = 2'b10;
  localparam logic [1:0]      T_SOLO = 2'b11;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t            r_state, w_state_nx;
  logic [VC_W-1:0]   r_lock_vc, w_lock_vc_nx;
  logic [VC_W-1:0]   r_last, w_last_nx;

  logic [DATA_W-1:0] r_mem   [NUM_VC][DEPTH];
  logic [AW-1:0]     r_wp    [NUM_VC];
  logic [AW-1:0]     r_rp    [NUM_VC];
  logic [CW-1:0]     r_cnt   [NUM_VC];
  logic [4:0]        r_route [NUM_VC];
  logic [NUM_VC-1:0] r_ack, r_lck;
  logic              r_ovf;

  logic [NUM_VC-1:0] w_nonempty, w_push_vec, w_pop_vec;
  logic              w_in_range, w_push, w_pop;
  logic [VC_W-1:0]   w_cand, w_rr_vc, w_sel;
  logic              w_rr_hit, w_valid;
  logic [DATA_W-1:0] w_head;
  logic [1:0]        w_type, w_in_type;
  logic [POS_W-1:0]  w_dx, w_dy;
  logic [4:0]        w_xy;

  // Ingress: acceptance depends only on start-of-cycle count (no bypass on pop)
  always_comb begin
    w_in_range = ({1'b0, bus.ivch} < NVC);
    w_push     = bus.ivalid && w_in_range && (r_cnt[bus.ivch] != FULL);
    w_push_vec = w_push ? (NUM_VC'(1) << bus.ivch) : '0;
    w_in_type  = bus.idata[DATA_W-1 -: 2];
  end

  // Round-robin candidate: first non-empty VC after the last-served one
  always_comb begin
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      w_nonempty[v] = (r_cnt[v] != '0);
    end
    w_rr_vc  = r_last;
    w_rr_hit = 1'b0;
    w_cand   = '0;
    for (int unsigned i = 1; i <= NUM_VC; i++) begin
      w_cand = VC_W'((int'(r_last) + int'(i)) % NUM_VC);
      if (!w_rr_hit && w_nonempty[w_cand]) begin
        w_rr_hit = 1'b1;
        w_rr_vc  = w_cand;
      end
    end
  end

  always_comb begin
    w_sel   = (r_state == S_LOCKED) ? r_lock_vc : w_rr_vc;
    w_valid = (r_state == S_LOCKED) ? w_nonempty[r_lock_vc] : w_rr_hit;
    w_head  = r_mem[w_sel][r_rp[w_sel]];
    w_type  = w_head[DATA_W-1 -: 2];
    w_dx    = w_head[2*POS_W-1 -: POS_W];
    w_dy    = w_head[POS_W-1:0];
    if      (w_dx > my_xpos) w_xy = 5'b00100;
    else if (w_dx < my_xpos) w_xy = 5'b10000;
    else if (w_dy > my_ypos) w_xy = 5'b00010;
    else if (w_dy < my_ypos) w_xy = 5'b01000;
    else                     w_xy = 5'b00001;
    w_pop     = w_valid && bus.igrant;
    w_pop_vec = w_pop ? (NUM_VC'(1) << w_sel) : '0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lock_vc <= '0;
      r_last    <= VC_W'(NUM_VC - 1);
    end else begin
      r_state   <= w_state_nx;
      r_lock_vc <= w_lock_vc_nx;
      r_last    <= w_last_nx;
    end
  end

  // Next state: packet boundaries are taken from the type of the granted flit
  always_comb begin
    w_state_nx   = r_state;
    w_lock_vc_nx = r_lock_vc;
    w_last_nx    = r_last;
    if (w_pop) begin
      case (w_type)
        T_HEAD: begin
          w_state_nx   = S_LOCKED;
          w_lock_vc_nx = w_sel;
        end
        T_TAIL, T_SOLO: begin
          w_state_nx = S_IDLE;
          w_last_nx  = w_sel;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.ovalid = w_valid;
    bus.odata  = '0;
    bus.ovch   = '0;
    bus.oport  = '0;
    if (w_valid) begin
      bus.odata = w_head;
      bus.ovch  = w_sel;
      bus.oport = w_type[0] ? w_xy : r_route[w_sel];
    end
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      bus.ordy[v] = (r_cnt[v] != FULL);
    end
    bus.olck = r_lck;
    bus.oack = r_ack;
    bus.oovf = r_ovf;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[bus.ivch][r_wp[bus.ivch]] <= bus.idata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        r_wp[v]    <= '0;
        r_rp[v]    <= '0;
        r_cnt[v]   <= '0;
        r_route[v] <= '0;
      end
      r_ack <= '0;
      r_lck <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_ack <= w_push_vec;
      if (w_push) begin
        r_wp[bus.ivch] <= r_wp[bus.ivch] + 1'b1;
        if (w_in_type == T_HEAD)      r_lck[bus.ivch] <= 1'b1;
        else if (w_in_type == T_TAIL) r_lck[bus.ivch] <= 1'b0;
      end else if (bus.ivalid && w_in_range) begin
        r_ovf <= 1'b1;
      end
      if (w_pop) begin
        r_rp[w_sel] <= r_rp[w_sel] + 1'b1;
        if (w_type[0]) r_route[w_sel] <= w_xy;
      end
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        if (w_push_vec[v] && !w_pop_vec[v])      r_cnt[v] <= r_cnt[v] + 1'b1;
        else if (!w_push_vec[v] && w_pop_vec[v]) r_cnt[v] <= r_cnt[v] - 1'b1;
      end
    end
  end
endmodule
